// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI transmitter / receiver pair.
//   - SPI_DATA_LENGTH / SPI_SHIFT_DIRECTION: link defaults both ends agree on.
//   - rx_state_t: receiver frame state.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int unsigned SPI_DATA_LENGTH     = 8;
    localparam bit          SHIFT_MSB_FIRST     = 1'b0;
    localparam bit          SHIFT_LSB_FIRST     = 1'b1;
    localparam bit          SPI_SHIFT_DIRECTION = SHIFT_MSB_FIRST;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo
//   First-word-fall-through FIFO used as the receiver output buffer when the
//   design is built with SPI_RX_FIFO_EN.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     write side; in_ready stays high when full if the
//                           head is popped in the same cycle
//     in_data  [WIDTH]      word to store
//     out_valid/out_ready   read side; out_data is the current head
//     out_data [WIDTH]      head word, zero while empty
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module spi_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             full;
    logic             push;
    logic             pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign in_ready  = !full || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by count_q alone and
    // out_data is masked while empty, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/spi_rx.sv
// -----------------------------------------------------------------------------
// spi_rx
//   Mode-0 SPI receiver. Synchronises MCLK / SS_N / MISO into the SCLK domain,
//   deserialises DATA_LENGTH-bit words and presents them on a valid/ready port.
//   Ports:
//     SCLK, RST_N   local clock, asynchronous active-low reset
//     MCLK          serial bit clock (async to SCLK), sampled on its rise
//     SS_N          active-low frame select
//     MISO          serial data
//     DATA_OUT      received word
//     OUT_VALID     DATA_OUT holds a word; accepted when OUT_READY is high
//     OUT_READY     consumer ready
//     BUSY          high while in SHIFT
//     OVERRUN       one-cycle pulse: a completed word was dropped
//     FRAME_ERR     one-cycle pulse: SS_N rose part-way through a word
//   Build option SPI_RX_FIFO_EN: completed words go through a FIFO_DEPTH-entry
//   FWFT FIFO instead of the single holding register.
//   SYNC_STAGES is legal in 2..3.
// -----------------------------------------------------------------------------
module spi_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_LENGTH     = SPI_DATA_LENGTH,
    parameter bit          SHIFT_DIRECTION = SPI_SHIFT_DIRECTION,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                   SCLK,
    input  logic                   RST_N,
    input  logic                   MCLK,
    input  logic                   SS_N,
    input  logic                   MISO,
    output logic [DATA_LENGTH-1:0] DATA_OUT,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   BUSY,
    output logic                   OVERRUN,
    output logic                   FRAME_ERR
);

    localparam int unsigned      CNT_W    = $clog2(DATA_LENGTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LENGTH - 1);

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] mclk_sync_q, mclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_n_sync_q, ss_n_sync_d;
    logic [SYNC_STAGES-1:0] miso_sync_q, miso_sync_d;
    logic                   mclk_dly_q,  mclk_dly_d;
    logic                   ss_n_dly_q,  ss_n_dly_d;
    logic                   mclk_s, ss_n_s, miso_s;
    logic                   mclk_rise, ss_n_fall, ss_n_rise;

    assign mclk_s = mclk_sync_q[SYNC_STAGES-1];
    assign ss_n_s = ss_n_sync_q[SYNC_STAGES-1];
    assign miso_s = miso_sync_q[SYNC_STAGES-1];

    // The delay flop holds the previous synced level, giving one-cycle strobes.
    assign mclk_rise = mclk_s && !mclk_dly_q;
    assign ss_n_fall = !ss_n_s && ss_n_dly_q;
    assign ss_n_rise = ss_n_s && !ss_n_dly_q;

    always_comb begin
        mclk_sync_d = {mclk_sync_q[SYNC_STAGES-2:0], MCLK};
        ss_n_sync_d = {ss_n_sync_q[SYNC_STAGES-2:0], SS_N};
        miso_sync_d = {miso_sync_q[SYNC_STAGES-2:0], MISO};
        mclk_dly_d  = mclk_s;
        ss_n_dly_d  = ss_n_s;
    end

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every flop samples pre-edge values.
    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            // SS_N resets high (inactive) so release never fakes a frame start.
            mclk_sync_q <= '0;
            ss_n_sync_q <= '1;
            miso_sync_q <= '0;
            mclk_dly_q  <= 1'b0;
            ss_n_dly_q  <= 1'b1;
        end else begin
            mclk_sync_q <= mclk_sync_d;
            ss_n_sync_q <= ss_n_sync_d;
            miso_sync_q <= miso_sync_d;
            mclk_dly_q  <= mclk_dly_d;
            ss_n_dly_q  <= ss_n_dly_d;
        end
    end

    // ----------------------------------------------------------- framing FSM
    rx_state_t              state_q,     state_d;
    logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [DATA_LENGTH-1:0] shift_q,     shift_d;
    logic                   frame_err_q, frame_err_d;
    logic [CNT_W-1:0]       cnt_next;
    logic [DATA_LENGTH-1:0] shifted;
    logic                   word_done;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        cnt_next    = bit_cnt_q;
        shifted     = SHIFT_DIRECTION ? {miso_s, shift_q[DATA_LENGTH-1:1]}
                                      : {shift_q[DATA_LENGTH-2:0], miso_s};
        case (state_q)
            IDLE: begin
                if (ss_n_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                // The bit is taken first; a simultaneous SS_N rise then sees
                // the post-sample count, so a just-finished word is not an error.
                if (mclk_rise) begin
                    shift_d = shifted;
                    if (bit_cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        cnt_next  = '0;
                    end else begin
                        cnt_next  = bit_cnt_q + 1'b1;
                    end
                end
                bit_cnt_d = cnt_next;
                if (ss_n_rise) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    frame_err_d = (cnt_next != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign BUSY      = (state_q == SHIFT);
    assign FRAME_ERR = frame_err_q;

    // ------------------------------------------------------------ output side
    logic overrun_q, overrun_d;

`ifdef SPI_RX_FIFO_EN
    logic fifo_in_ready;

    spi_rx_fifo #(
        .WIDTH (DATA_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (SCLK),
        .rst_n     (RST_N),
        .in_valid  (word_done),
        .in_data   (shifted),
        .in_ready  (fifo_in_ready),
        .out_valid (OUT_VALID),
        .out_data  (DATA_OUT),
        .out_ready (OUT_READY)
    );

    always_comb begin
        overrun_d = word_done && !fifo_in_ready;
    end
`else
    logic [DATA_LENGTH-1:0] data_q,  data_d;
    logic                   valid_q, valid_d;

    // A held, unaccepted word has priority: a newer one is dropped, never
    // overwritten, unless the held one is being accepted this same cycle.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (word_done) begin
            if (!valid_q || OUT_READY) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && OUT_READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign DATA_OUT  = data_q;
    assign OUT_VALID = valid_q;
`endif

    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_rx
//   Two receivers share one serial stream: one MSB-first, one LSB-first.
//   A mode-0 transmitter model drives MCLK with 3-SCLK half periods; a monitor
//   records accepted words and status pulses; expected words come from the
//   transmitted values (bit-reversed for the LSB-first receiver).
// -----------------------------------------------------------------------------
module tb_spi_rx;

    localparam int DL = 8;
    localparam int SS = 2;

    logic          SCLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          MCLK = 1'b0;
    logic          SS_N = 1'b1;
    logic          MISO = 1'b0;
    logic          OUT_READY = 1'b1;
    logic [DL-1:0] data_m, data_l;
    logic          valid_m, valid_l, busy_m, busy_l;
    logic          ovr_m, ovr_l, ferr_m, ferr_l;

    always #5 SCLK = ~SCLK;

    spi_rx #(.DATA_LENGTH(DL), .SHIFT_DIRECTION(1'b0), .SYNC_STAGES(SS), .FIFO_DEPTH(4)) u_dut_msb (
        .SCLK(SCLK), .RST_N(RST_N), .MCLK(MCLK), .SS_N(SS_N), .MISO(MISO),
        .DATA_OUT(data_m), .OUT_VALID(valid_m), .OUT_READY(OUT_READY),
        .BUSY(busy_m), .OVERRUN(ovr_m), .FRAME_ERR(ferr_m)
    );

    spi_rx #(.DATA_LENGTH(DL), .SHIFT_DIRECTION(1'b1), .SYNC_STAGES(SS), .FIFO_DEPTH(4)) u_dut_lsb (
        .SCLK(SCLK), .RST_N(RST_N), .MCLK(MCLK), .SS_N(SS_N), .MISO(MISO),
        .DATA_OUT(data_l), .OUT_VALID(valid_l), .OUT_READY(OUT_READY),
        .BUSY(busy_l), .OVERRUN(ovr_l), .FRAME_ERR(ferr_l)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ monitor
    // Sampled mid-cycle: outputs settled since the rising edge, and OUT_READY
    // already holds the value the DUT will see at the next rising edge.
    logic [DL-1:0] got_m[$];
    logic [DL-1:0] got_l[$];
    int n_ovr_m = 0, n_ovr_l = 0, n_ferr_m = 0, n_ferr_l = 0;

    always @(negedge SCLK) begin
        #1;
        if (RST_N) begin
            if (valid_m && OUT_READY) got_m.push_back(data_m);
            if (valid_l && OUT_READY) got_l.push_back(data_l);
            if (ovr_m)  n_ovr_m++;
            if (ovr_l)  n_ovr_l++;
            if (ferr_m) n_ferr_m++;
            if (ferr_l) n_ferr_l++;
        end
    end

    task automatic clear_mon();
        got_m.delete();
        got_l.delete();
        n_ovr_m = 0; n_ovr_l = 0; n_ferr_m = 0; n_ferr_l = 0;
    endtask

    function automatic logic [DL-1:0] head(input logic [DL-1:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 'x;
    endfunction

    function automatic logic [DL-1:0] rev(input logic [DL-1:0] w);
        logic [DL-1:0] r;
        for (int i = 0; i < DL; i++) r[i] = w[DL-1-i];
        return r;
    endfunction

    // ---------------------------------------------------- transmitter model
    task automatic tick(input int n);
        repeat (n) @(negedge SCLK);
    endtask

    task automatic send_bit(input logic b);
        MISO = b;
        tick(3);
        MCLK = 1'b1;
        tick(3);
        MCLK = 1'b0;
    endtask

    task automatic send_word(input logic [DL-1:0] w);
        for (int i = DL - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic frame_open();
        SS_N = 1'b0;
        tick(4);
    endtask

    task automatic frame_close();
        tick(3);
        SS_N = 1'b1;
        tick(8);
    endtask

    typedef struct {
        logic [DL-1:0] data;
        logic [DL-1:0] exp_m;
        logic [DL-1:0] exp_l;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [DL-1:0] exp_q[$];
        int exp_ferr;

        vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[1] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[2] = '{8'h80, 8'h80, 8'h01};
        vecs[3] = '{8'h12, 8'h12, 8'h48};
        vecs[4] = '{8'hF0, 8'hF0, 8'h0F};
        vecs[5] = '{8'h00, 8'h00, 8'h00};

        // Reset state.
        tick(3);
        check("rst_data",  data_m,  0);
        check("rst_valid", valid_m, 0);
        check("rst_busy",  busy_m,  0);
        check("rst_ovr",   ovr_m,   0);
        check("rst_ferr",  ferr_m,  0);
        RST_N = 1'b1;
        tick(4);

        // Table: one word per frame, consumer always ready.
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            frame_open();
            check("busy_open", busy_m, 1);
            send_word(vecs[v].data);
            check("busy_word_end", busy_m, 1);
            frame_close();
            check("busy_closed", busy_m, 0);
            check("beats_m", got_m.size(), 1);
            check("word_m",  head(got_m, 0), vecs[v].exp_m);
            check("word_l",  head(got_l, 0), vecs[v].exp_l);
            check("no_ovr",  n_ovr_m + n_ovr_l, 0);
            check("no_ferr", n_ferr_m + n_ferr_l, 0);
        end

        // Two words in one frame.
        clear_mon();
        frame_open();
        send_word(8'h3C);
        send_word(8'hC3);
        frame_close();
        check("multi_beats", got_m.size(), 2);
        check("multi_w0", head(got_m, 0), 8'h3C);
        check("multi_w1", head(got_m, 1), 8'hC3);
        check("multi_w1_l", head(got_l, 1), 8'hC3);
        check("multi_status", n_ovr_m + n_ferr_m + n_ovr_l + n_ferr_l, 0);

        // Latency from the first SCLK edge that sees MCLK high on the last bit.
        clear_mon();
        frame_open();
        for (int i = DL - 1; i >= 1; i--) send_bit(1'(8'h96 >> i));
        MISO = 1'b0;
        tick(3);
        MCLK = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge SCLK);
            #1;
            if (valid_m) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, SS + 1);
        tick(2);
        MCLK = 1'b0;
        frame_close();
        check("lat_word", head(got_m, 0), 8'h96);

`ifndef SPI_RX_FIFO_EN
        // Overrun with the holding register.
        OUT_READY = 1'b0;
        clear_mon();
        frame_open();
        send_word(8'h11);
        send_word(8'h22);
        frame_close();
        check("ovr_data_held", data_m, 8'h11);
        check("ovr_data_held_l", data_l, 8'h88);
        check("ovr_valid", valid_m, 1);
        check("ovr_pulses_m", n_ovr_m, 1);
        check("ovr_pulses_l", n_ovr_l, 1);
        OUT_READY = 1'b1;
        tick(3);
        check("ovr_drain_n", got_m.size(), 1);
        check("ovr_drain_w", head(got_m, 0), 8'h11);
        check("ovr_valid_drop", valid_m, 0);
        check("ovr_data_kept", data_m, 8'h11);
`else
        // FIFO fill past capacity, then drain.
        OUT_READY = 1'b0;
        clear_mon();
        frame_open();
        for (int w = 1; w <= 5; w++) send_word(DL'(w));
        frame_close();
        check("fifo_ovr", n_ovr_m, 1);
        check("fifo_head", data_m, 8'h01);
        OUT_READY = 1'b1;
        tick(8);
        check("fifo_drain_n", got_m.size(), 4);
        for (int w = 0; w < 4; w++) begin
            check("fifo_drain_m", head(got_m, w), DL'(w + 1));
            check("fifo_drain_l", head(got_l, w), rev(DL'(w + 1)));
        end
        check("fifo_empty", valid_m, 0);
`endif

        // Frame error after 5 bits, then a clean frame.
        clear_mon();
        frame_open();
        for (int i = DL - 1; i >= DL - 5; i--) send_bit(1'(8'h5A >> i));
        frame_close();
        check("ferr_m", n_ferr_m, 1);
        check("ferr_l", n_ferr_l, 1);
        check("ferr_no_beat", got_m.size(), 0);
        frame_open();
        send_word(8'h5A);
        frame_close();
        check("after_ferr_w", head(got_m, 0), 8'h5A);
        check("after_ferr_cnt", n_ferr_m, 1);

        // Reset in the middle of a word.
        clear_mon();
        frame_open();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        RST_N = 1'b0;
        tick(1);
        check("midrst_data",  data_m,  0);
        check("midrst_valid", valid_m, 0);
        check("midrst_busy",  busy_m,  0);
        SS_N = 1'b1;
        tick(3);
        RST_N = 1'b1;
        tick(4);
        frame_open();
        send_word(8'hFF);
        frame_close();
        check("postrst_n", got_m.size(), 1);
        check("postrst_w", head(got_m, 0), 8'hFF);
        check("postrst_ferr", n_ferr_m, 0);

        // Random frames against a word-queue reference model.
        clear_mon();
        exp_q.delete();
        exp_ferr = 0;
        for (int f = 0; f < 25; f++) begin
            int nw;
            nw = $urandom_range(1, 3);
            frame_open();
            for (int w = 0; w < nw; w++) begin
                logic [DL-1:0] d;
                d = DL'($urandom);
                exp_q.push_back(d);
                send_word(d);
            end
            if ($urandom_range(0, 1) == 1) begin
                int nb;
                nb = $urandom_range(1, DL - 1);
                for (int b = 0; b < nb; b++) send_bit(1'($urandom));
                exp_ferr++;
            end
            tick($urandom_range(0, 5));
            frame_close();
        end
        check("rand_count_m", got_m.size(), exp_q.size());
        check("rand_count_l", got_l.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check("rand_word_m", head(got_m, i), exp_q[i]);
            check("rand_word_l", head(got_l, i), rev(exp_q[i]));
        end
        check("rand_ferr_m", n_ferr_m, exp_ferr);
        check("rand_ferr_l", n_ferr_l, exp_ferr);
        check("rand_ovr", n_ovr_m + n_ovr_l, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
